// File: rtl/frame_hdr_pkg.sv
// frame_hdr_pkg
//   Shared definitions for the frame header parser: FSM state encoding,
//   default geometry, and width helper functions used by the top and the
//   header capture sub-module.
package frame_hdr_pkg;

  // Parser FSM states
  localparam logic [1:0] ST_DRAIN = 2'd0;  // wait for the current frame to end
  localparam logic [1:0] ST_IDLE  = 2'd1;  // wait for a frame start
  localparam logic [1:0] ST_HDR   = 2'd2;  // consuming header words
  localparam logic [1:0] ST_BODY  = 2'd3;  // counting payload beats

  // Default geometry
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_LEN_BYTES = 2;
  localparam int LEN_W         = DEF_DATA_W * DEF_LEN_BYTES;

  // Width of a counter that must hold 0..hdr_bytes
  function automatic int byte_cnt_w(input int hdr_bytes);
    return $clog2(hdr_bytes + 1);
  endfunction

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_hdr_capture.sv
// frame_hdr_capture
//   Header word capture and byte counter. Stores words 0..LEN_BYTES of the
//   header as they arrive; reserved words only advance the counter.
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start_i         clears the byte counter (frame start)
//   word_valid_i    a header word is consumed this cycle
//   word_i          header word
//   last_word_o     current consumed word is the final header word
//   eid_o           header word 0
//   len_o           words 1..LEN_BYTES, MSB first; includes the current word
//                   when the length field ends the header
module frame_hdr_capture
  import frame_hdr_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int HDR_BYTES = 4,
  parameter int LEN_BYTES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic                        word_valid_i,
  input  logic [DATA_W-1:0]           word_i,
  output logic                        last_word_o,
  output logic [DATA_W-1:0]           eid_o,
  output logic [DATA_W*LEN_BYTES-1:0] len_o
);

  localparam int BCW = byte_cnt_w(HDR_BYTES);

  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;

  assign last_word_o = word_valid_i && (byte_cnt_q == BCW'(HDR_BYTES - 1));

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (start_i)
      byte_cnt_d = '0;
    else if (word_valid_i && !last_word_o)
      byte_cnt_d = byte_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      byte_cnt_q <= '0;
    else
      byte_cnt_q <= byte_cnt_d;
  end

  genvar gi;
  generate
    for (gi = 0; gi <= LEN_BYTES; gi++) begin : g_word
      logic [DATA_W-1:0] word_q;
      logic [DATA_W-1:0] view;

      always_ff @(posedge clk) begin
        if (rst)
          word_q <= '0;
        else if (word_valid_i && byte_cnt_q == BCW'(gi))
          word_q <= word_i;
      end

      // With no reserved words the length LSB is the final word; it is not
      // registered yet when the fields are published, so forward it.
      if (gi == HDR_BYTES - 1) begin : g_fwd
        assign view = word_i;
      end else begin : g_reg
        assign view = word_q;
      end
    end

    for (gi = 1; gi <= LEN_BYTES; gi++) begin : g_len
      assign len_o[(LEN_BYTES-gi)*DATA_W +: DATA_W] = g_word[gi].view;
    end
  endgenerate

  assign eid_o = g_word[0].word_q;

endmodule

// File: rtl/frame_header_parser.sv
// frame_header_parser
//   Parses a fixed-length frame header (EID, big-endian length, reserved
//   words), publishes the fields, then counts payload beats and flags a
//   length mismatch or a frame that ends inside its header.
// Optional feature: define EID_FILTER_EN to qualify header_done with an
//   EID value/mask filter; otherwise header_match is constant 1.
// Ports
//   clk, rst               clock, synchronous active-high reset
//   in_frame_data[_valid]  stream word and its valid
//   in_frame_valid         frame in progress
//   frame_data_latch       comb: word consumed / frame start accepted
//   payload_latch          downstream consumed one payload word
//   header_eid/len         captured header fields
//   is_fragment            length field all-ones
//   header_done(_clear)    sticky header-valid flag and its clear
//   hdr_error, len_error   one-cycle error pulses
//   eid_match_val/mask     EID filter (EID_FILTER_EN only)
//   header_match           EID passed filter
module frame_header_parser
  import frame_hdr_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int HDR_BYTES = 4,
  parameter int LEN_BYTES = 2,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           in_frame_data,
  input  logic                        in_frame_data_valid,
  input  logic                        in_frame_valid,
  output logic                        frame_data_latch,
  input  logic                        payload_latch,
  output logic [DATA_W-1:0]           header_eid,
  output logic [DATA_W*LEN_BYTES-1:0] header_len,
  output logic                        is_fragment,
  output logic                        header_done,
  input  logic                        header_done_clear,
  output logic                        hdr_error,
  output logic                        len_error,
  input  logic [DATA_W-1:0]           eid_match_val,
  input  logic [DATA_W-1:0]           eid_match_mask,
  output logic                        header_match
);

  localparam int FIELD_W = DATA_W * LEN_BYTES;
  localparam int CMP_W   = max_w(CNT_W, FIELD_W);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   pay_cnt_q, pay_cnt_d;
  logic [DATA_W-1:0]  eid_q, eid_d;
  logic [FIELD_W-1:0] len_q, len_d;
  logic               frag_q, frag_d;
  logic               done_q, done_d;
  logic               hdr_err_q, hdr_err_d;
  logic               len_err_q, len_err_d;

  logic               cap_start, cap_valid, cap_last;
  logic [DATA_W-1:0]  cap_eid;
  logic [FIELD_W-1:0] cap_len;
  logic               match_now;

  assign cap_start = (state_q == ST_IDLE) && in_frame_valid;
  assign cap_valid = (state_q == ST_HDR) && in_frame_data_valid;

  frame_hdr_capture #(
    .DATA_W    (DATA_W),
    .HDR_BYTES (HDR_BYTES),
    .LEN_BYTES (LEN_BYTES)
  ) u_capture (
    .clk          (clk),
    .rst          (rst),
    .start_i      (cap_start),
    .word_valid_i (cap_valid),
    .word_i       (in_frame_data),
    .last_word_o  (cap_last),
    .eid_o        (cap_eid),
    .len_o        (cap_len)
  );

`ifdef EID_FILTER_EN
  logic match_q;

  assign match_now = ((cap_eid ^ eid_match_val) & eid_match_mask) == '0;

  always_ff @(posedge clk) begin
    if (rst)
      match_q <= 1'b0;
    else if (cap_last)
      match_q <= match_now;
  end

  assign header_match = match_q;
`else
  logic unused_filter;

  assign unused_filter = ^{eid_match_val, eid_match_mask};
  assign match_now     = 1'b1;
  assign header_match  = 1'b1;
`endif

  always_comb begin
    state_d          = state_q;
    pay_cnt_d        = pay_cnt_q;
    eid_d            = eid_q;
    len_d            = len_q;
    frag_d           = frag_q;
    hdr_err_d        = 1'b0;
    len_err_d        = 1'b0;
    frame_data_latch = 1'b0;
    // A header completing in the same cycle as a clear keeps header_done set.
    done_d           = header_done_clear ? 1'b0 : done_q;

    case (state_q)
      ST_DRAIN: begin
        if (!in_frame_valid)
          state_d = ST_IDLE;
      end
      ST_IDLE: begin
        frame_data_latch = in_frame_valid;
        if (in_frame_valid)
          state_d = ST_HDR;
      end
      ST_HDR: begin
        frame_data_latch = in_frame_data_valid;
        if (cap_last) begin
          eid_d     = cap_eid;
          len_d     = cap_len;
          frag_d    = &cap_len;
          pay_cnt_d = '0;
          if (match_now)
            done_d = 1'b1;
          state_d = ST_BODY;
        end else if (!in_frame_valid && !in_frame_data_valid) begin
          hdr_err_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin  // ST_BODY
        if (payload_latch && pay_cnt_q != '1)
          pay_cnt_d = pay_cnt_q + 1'b1;
        // A beat coincident with the frame end still counts toward the length.
        if (!in_frame_valid) begin
          len_err_d = !frag_q && (CMP_W'(pay_cnt_d) != CMP_W'(len_q));
          state_d   = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_DRAIN;
      pay_cnt_q <= '0;
      eid_q     <= '0;
      len_q     <= '0;
      frag_q    <= 1'b0;
      done_q    <= 1'b0;
      hdr_err_q <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pay_cnt_q <= pay_cnt_d;
      eid_q     <= eid_d;
      len_q     <= len_d;
      frag_q    <= frag_d;
      done_q    <= done_d;
      hdr_err_q <= hdr_err_d;
      len_err_q <= len_err_d;
    end
  end

  assign header_eid  = eid_q;
  assign header_len  = len_q;
  assign is_fragment = frag_q;
  assign header_done = done_q;
  assign hdr_error   = hdr_err_q;
  assign len_error   = len_err_q;

endmodule

// File: tb/tb_frame_header_parser.sv
// Self-checking bench for frame_header_parser (default geometry).
// Expected header/error events are queued as stimulus is driven and
// compared when the DUT raises header_done, len_error or hdr_error.
module tb_frame_header_parser;

  logic        clk;
  logic        rst;
  logic [7:0]  in_frame_data;
  logic        in_frame_data_valid;
  logic        in_frame_valid;
  logic        frame_data_latch;
  logic        payload_latch;
  logic [7:0]  header_eid;
  logic [15:0] header_len;
  logic        is_fragment;
  logic        header_done;
  logic        header_done_clear;
  logic        hdr_error;
  logic        len_error;
  logic [7:0]  eid_match_val;
  logic [7:0]  eid_match_mask;
  logic        header_match;

  frame_header_parser dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_frame_data       (in_frame_data),
    .in_frame_data_valid (in_frame_data_valid),
    .in_frame_valid      (in_frame_valid),
    .frame_data_latch    (frame_data_latch),
    .payload_latch       (payload_latch),
    .header_eid          (header_eid),
    .header_len          (header_len),
    .is_fragment         (is_fragment),
    .header_done         (header_done),
    .header_done_clear   (header_done_clear),
    .hdr_error           (hdr_error),
    .len_error           (len_error),
    .eid_match_val       (eid_match_val),
    .eid_match_mask      (eid_match_mask),
    .header_match        (header_match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 = header done, 1 = len_error, 2 = hdr_error
    logic [7:0]  eid;
    logic [15:0] len;
    logic        frag;
  } ev_t;

  ev_t sb_q[$];
  int  checks = 0;
  int  errors = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic [7:0] eid, input logic [15:0] len);
    ev_t e;
    e.kind = kind;
    e.eid  = eid;
    e.len  = len;
    e.frag = (len == 16'hFFFF);
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input int kind);
    ev_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_unexpected: observed event %0d expected none", kind);
    end else begin
      e = sb_q.pop_front();
      chk("sb_kind", kind, e.kind);
      if (e.kind == 0 && kind == 0) begin
        chk("sb_eid", {24'd0, header_eid}, {24'd0, e.eid});
        chk("sb_len", {16'd0, header_len}, {16'd0, e.len});
        chk("sb_frag", {31'd0, is_fragment}, {31'd0, e.frag});
      end
      $display("event kind=%0d eid=%02h len=%04h frag=%0b", kind, header_eid, header_len, is_fragment);
    end
  endtask

  // Monitor: sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (header_done && !prev_done) sb_check(0);
    if (len_error) sb_check(1);
    if (hdr_error) sb_check(2);
    prev_done = header_done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_header(input logic [7:0] eid, input logic [15:0] len,
                             input bit exp_done, input bit clr_on_last);
    logic [7:0] w [4];
    w[0] = eid; w[1] = len[15:8]; w[2] = len[7:0]; w[3] = 8'h00;
    in_frame_valid = 1'b1;
    #1;
    chk("start_latch", {31'd0, frame_data_latch}, 32'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      in_frame_data       = w[i];
      in_frame_data_valid = 1'b1;
      if (i == 3) begin
        if (exp_done) push_ev(0, eid, len);
        header_done_clear = clr_on_last;
      end
      #1;
      if (i == 0) chk("hdr_latch", {31'd0, frame_data_latch}, 32'd1);
      if (i == 3) chk("done_before_last", {31'd0, header_done}, 32'd0);
      tick();
    end
    in_frame_data_valid = 1'b0;
    header_done_clear   = 1'b0;
    chk("done_latency", {31'd0, header_done}, {31'd0, exp_done});
  endtask

  task automatic finish_frame(input int beats, input bit exp_len_err);
    for (int i = 0; i < beats; i++) begin
      payload_latch = 1'b1;
      tick();
      payload_latch = 1'b0;
      tick();
    end
    if (exp_len_err) push_ev(1, 8'h00, 16'h0000);
    in_frame_valid = 1'b0;
    tick();
    tick();
    header_done_clear = 1'b1;
    tick();
    header_done_clear = 1'b0;
    chk("done_cleared", {31'd0, header_done}, 32'd0);
  endtask

  initial begin
    rst                 = 1'b1;
    in_frame_data       = 8'h00;
    in_frame_data_valid = 1'b0;
    in_frame_valid      = 1'b0;
    payload_latch       = 1'b0;
    header_done_clear   = 1'b0;
    eid_match_val       = 8'h10;
    eid_match_mask      = 8'hF0;
    tick();
    tick();
    chk("rst_done", {31'd0, header_done}, 32'd0);
    chk("rst_eid", {24'd0, header_eid}, 32'd0);
    chk("rst_len", {16'd0, header_len}, 32'd0);
    chk("rst_frag", {31'd0, is_fragment}, 32'd0);
    chk("rst_errs", {30'd0, hdr_error, len_error}, 32'd0);
    chk("rst_latch", {31'd0, frame_data_latch}, 32'd0);
    rst = 1'b0;
    tick();

    // Nominal frame, exact length
    send_header(8'h12, 16'h0003, 1'b1, 1'b0);
    finish_frame(3, 1'b0);
    chk("match_default", {31'd0, header_match}, 32'd1);

    // Short payload -> length error
    send_header(8'h12, 16'h0003, 1'b1, 1'b0);
    finish_frame(2, 1'b1);

    // Fragment: all-ones length, any payload count
    send_header(8'h13, 16'hFFFF, 1'b1, 1'b0);
    chk("frag_flag", {31'd0, is_fragment}, 32'd1);
    finish_frame(7, 1'b0);

    // Truncated header
    in_frame_valid = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      in_frame_data       = 8'h14 + 8'(i);
      in_frame_data_valid = 1'b1;
      tick();
    end
    in_frame_data_valid = 1'b0;
    in_frame_valid      = 1'b0;
    push_ev(2, 8'h00, 16'h0000);
    tick();
    tick();
    chk("trunc_no_done", {31'd0, header_done}, 32'd0);
    send_header(8'h15, 16'h0001, 1'b1, 1'b0);
    finish_frame(1, 1'b0);

    // Reset mid-BODY while the frame is still running
    send_header(8'h16, 16'h0004, 1'b1, 1'b0);
    payload_latch = 1'b1;
    tick();
    payload_latch = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_done", {31'd0, header_done}, 32'd0);
    chk("midrst_eid", {24'd0, header_eid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      in_frame_data       = 8'h17;
      in_frame_data_valid = 1'b1;
      #1;
      chk("drain_latch", {31'd0, frame_data_latch}, 32'd0);
      tick();
    end
    chk("drain_no_done", {31'd0, header_done}, 32'd0);
    in_frame_data_valid = 1'b0;
    in_frame_valid      = 1'b0;
    tick();
    send_header(8'h18, 16'h0002, 1'b1, 1'b0);
    finish_frame(2, 1'b0);

    // Clear coincident with the last header word: set wins
    send_header(8'h19, 16'h0001, 1'b1, 1'b1);
    finish_frame(1, 1'b0);

`ifdef EID_FILTER_EN
    send_header(8'h1A, 16'h0003, 1'b1, 1'b0);
    chk("filter_hit", {31'd0, header_match}, 32'd1);
    finish_frame(3, 1'b0);
    send_header(8'h2A, 16'h0003, 1'b0, 1'b0);
    chk("filter_miss", {31'd0, header_match}, 32'd0);
    chk("filter_miss_eid", {24'd0, header_eid}, 32'h2A);
    finish_frame(2, 1'b1);
`endif

    tick();
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
